fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage plus IF/ID register of the pipelined OTTER core. Owns the PC, issues word fetches on a
//  req/gnt/rvalid instruction-memory port, buffers returning words, and presents {instr, pc, pc+4}
//  to decode. imm_d = instr_d[31:7] feeds the decode-stage immediate extender directly.
// PARAMETERS
//  RESET_VEC  32'h0000_0000  PC value loaded on reset
//  BUF_DEPTH  2              instruction-buffer entries (power of 2, >=2); also max in-flight fetches
// PORTS
//  clk          in   1   core clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  stall_d      in   1   hazard unit: hold IF/ID register and PC
//  flush_d      in   1   hazard unit: invalidate IF/ID register next edge
//  pc_src_e     in   1   redirect taken in EX (branch/jump)
//  pc_target_e  in   32  redirect target (bits[1:0] ignored, forced 0)
//  imem_req     out  1   fetch request valid
//  imem_addr    out  32  fetch word address (= PC)
//  imem_gnt     in   1   request accepted this cycle
//  imem_rvalid  in   1   response valid (in order, >=1 cycle after gnt)
//  imem_rdata   in   32  response instruction word
//  valid_d      out  1   IF/ID holds a real instruction
//  instr_d      out  32  instruction to decode (NOP_INSTR when !valid_d)
//  imm_d        out  25  instr_d[31:7], to immediate extender
//  pc_d         out  32  PC of instr_d
//  pc_plus4_d   out  32  pc_d + 4 (mod 2^32)
//  perf_fetch   out  32  instructions delivered to decode (see CONFIGURATION)
//  perf_drop    out  32  responses discarded after redirect (see CONFIGURATION)
// BEHAVIOUR
//  Reset: PC=RESET_VEC, buffer empty, inflight=0, drop=0, valid_d=0, instr_d=NOP_INSTR, pc_d=0,
//   pc_plus4_d=4, imem_req=0 during reset, perf counters 0. Reset mid-fetch abandons all in-flight.
//  Issue: imem_req=1 iff (inflight + buf_count) < BUF_DEPTH and !pc_src_e. On req&gnt: PC+=4,
//   inflight++. imem_addr stable while req held without gnt.
//  Response: on rvalid, inflight--; if drop>0 then drop--, word discarded (perf_drop++);
//   else word pushed with its PC (response PC tracked in order). Credit rule guarantees no overflow.
//  IF/ID load (edge, !stall_d): buffer nonempty -> pop head into IF/ID, valid_d=1, perf_fetch++;
//   empty -> bubble (valid_d=0, instr_d=NOP_INSTR). A response arriving the same cycle with an empty
//   buffer bypasses into IF/ID (zero-bubble path). stall_d=1: IF/ID and PC hold; fetch continues to fill.
//  Redirect (pc_src_e=1): PC<=target, buffer cleared, drop<=inflight (minus any rvalid this cycle,
//   which is itself discarded), no request issued that cycle; first fetch of target next cycle.
//  flush_d=1: valid_d<=0, instr_d<=NOP_INSTR regardless of stall_d (flush wins over stall).
//  Latency: redirect -> target visible at valid_d min 3 edges (issue, rvalid, IF/ID load).
//  PC wrap: 32'hFFFF_FFFC+4 = 0, no error.
// CONFIGURATION
//  FETCH_PERF_EN defined: perf_fetch/perf_drop count as above, 32-bit wrapping, cleared only by reset.
//  Not defined: both ports tied to 0; counter logic not instantiated.
// STRUCTURE
//  otter_pipe_pkg: NOP_INSTR=32'h0000_0013, fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}.
//  Sub-module fetch_buffer: BUF_DEPTH-entry FIFO of fetch_entry_t with push/pop/clear, count, empty/full;
//   clear has priority over push in the same cycle.
// TESTING
//  1 Zero-wait memory (gnt=1, rvalid 1 cycle later), no stalls -> valid_d high from edge 3, pc_d
//    0,4,8,... one per cycle, imm_d == instr_d[31:7].
//  2 stall_d held 4 cycles at pc_d=0x8 -> pc_d/instr_d frozen, imem_req drops once buffer+inflight=2,
//    release -> 0xC,0x10 delivered on consecutive edges, none lost or duplicated.
//  3 Redirect pc_src_e=1 target 0x100 with 2 in flight -> both responses dropped (perf_drop=2),
//    next delivered pc_d=0x100.
//  4 flush_d and stall_d together -> valid_d=0, instr_d=32'h0000_0013 next edge.
//  5 gnt held low 5 cycles -> imem_addr constant, PC not incremented, valid_d bubbles.
//  6 rst_n asserted with 2 in flight and buffer full -> all outputs at reset values immediately;
//    post-release first fetch addr=RESET_VEC; without FETCH_PERF_EN perf ports read 0.

Source files
------------

// File: rtl/otter_pipe_pkg.sv
// Shared OTTER pipeline types: NOP encoding and the fetch entry
// bundle carried from the fetch buffer into the IF/ID register.
package otter_pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Fetch instruction buffer: DEPTH-entry FIFO of fetch_entry_t.
// Ports: i_clear/i_push/i_data/i_pop in; o_head/o_count/o_empty/o_full out.
import otter_pipe_pkg::*;

module fetch_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  fetch_entry_t               i_data,
  input  logic                       i_pop,
  output fetch_entry_t               o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  fetch_entry_t  r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign o_count = r_cnt;
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_head  = r_mem[r_rp];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wp] <= i_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// OTTER IF stage + IF/ID register: PC, req/gnt/rvalid fetch, buffer.
// Ports: hazard ctl, EX redirect, imem port, decode bundle, perf.
// Macro FETCH_PERF_EN enables perf_fetch/perf_drop counters.
import otter_pipe_pkg::*;

module fetch_stage #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid_d,
  output logic [31:0] instr_d,
  output logic [24:0] imm_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_drop
);

  localparam int            CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_L = (CW+1)'(BUF_DEPTH);

  logic [31:0]   r_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop;
  logic          r_valid;
  logic [31:0]   r_instr;
  logic [31:0]   r_pc_d;
  logic [31:0]   r_pc4;

  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  fetch_entry_t  w_head;
  fetch_entry_t  w_in;
  fetch_entry_t  w_ld;
  logic [31:0]   w_tgt;
  logic [CW:0]   w_occ;
  logic          w_req;
  logic          w_issue;
  logic          w_rsp;
  logic          w_drop_rsp;
  logic          w_keep;
  logic          w_load;
  logic          w_pop;
  logic          w_bypass;
  logic          w_push;
  logic          w_nxt_valid;
  logic [31:0]   w_nxt_instr;
  logic [31:0]   w_nxt_pc;
  logic [31:0]   w_nxt_pc4;
  logic          w_unused;

  assign w_unused = ^{pc_target_e[1:0], w_full};

  assign w_tgt = {pc_target_e[31:2], 2'b00};

  // Credit: every in-flight fetch must have a buffer slot waiting.
  assign w_occ   = {1'b0, r_inflight} + {1'b0, w_count};
  assign w_req   = rst_n & ~pc_src_e & (w_occ < DEPTH_L);
  assign w_issue = w_req & imem_gnt;

  // Stray rvalid with nothing outstanding is ignored.
  assign w_rsp      = imem_rvalid & (r_inflight != '0);
  assign w_drop_rsp = w_rsp & (pc_src_e | (r_drop != '0));
  assign w_keep     = w_rsp & ~w_drop_rsp;

  assign w_load   = ~stall_d & ~flush_d;
  assign w_pop    = w_load & ~w_empty;
  assign w_bypass = w_load & w_empty & w_keep;
  assign w_push   = w_keep & ~w_bypass;

  assign w_in = '{pc: r_rsp_pc, instr: imem_rdata};
  assign w_ld = w_empty ? w_in : w_head;

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (pc_src_e),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // r_rsp_pc is the PC of the next response that will be kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_VEC;
      r_rsp_pc   <= RESET_VEC;
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      if (pc_src_e) begin
        r_pc     <= w_tgt;
        r_rsp_pc <= w_tgt;
      end else begin
        if (w_issue) r_pc <= r_pc + 32'd4;
        if (w_keep)  r_rsp_pc <= r_rsp_pc + 32'd4;
      end
      r_inflight <= r_inflight + CW'(w_issue) - CW'(w_rsp);
      if (pc_src_e)
        r_drop <= r_inflight - CW'(w_rsp);
      else if (w_rsp && r_drop != '0)
        r_drop <= r_drop - CW'(1);
    end
  end

  always_comb begin
    w_nxt_valid = r_valid;
    w_nxt_instr = r_instr;
    w_nxt_pc    = r_pc_d;
    w_nxt_pc4   = r_pc4;
    unique case (1'b1)
      flush_d: begin
        w_nxt_valid = 1'b0;
        w_nxt_instr = NOP_INSTR;
      end
      (stall_d & ~flush_d): begin
      end
      (w_pop | w_bypass): begin
        w_nxt_valid = 1'b1;
        w_nxt_instr = w_ld.instr;
        w_nxt_pc    = w_ld.pc;
        w_nxt_pc4   = w_ld.pc + 32'd4;
      end
      default: begin
        w_nxt_valid = 1'b0;
        w_nxt_instr = NOP_INSTR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc_d  <= 32'd0;
      r_pc4   <= 32'd4;
    end else begin
      r_valid <= w_nxt_valid;
      r_instr <= w_nxt_instr;
      r_pc_d  <= w_nxt_pc;
      r_pc4   <= w_nxt_pc4;
    end
  end

  assign imem_req   = w_req;
  assign imem_addr  = r_pc;
  assign valid_d    = r_valid;
  assign instr_d    = r_instr;
  assign imm_d      = r_instr[31:7];
  assign pc_d       = r_pc_d;
  assign pc_plus4_d = r_pc4;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetch <= '0;
      r_perf_drop  <= '0;
    end else begin
      r_perf_fetch <= r_perf_fetch + 32'(w_pop | w_bypass);
      r_perf_drop  <= r_perf_drop + 32'(w_drop_rsp);
    end
  end

  assign perf_fetch = r_perf_fetch;
  assign perf_drop  = r_perf_drop;
`else
  assign perf_fetch = 32'd0;
  assign perf_drop  = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory model, in-order
// scoreboard of delivered PCs, directed and randomized scenarios.
module tb_fetch_stage;
  import otter_pipe_pkg::*;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall_d;
  logic        flush_d;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [24:0] imm_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic [31:0] perf_fetch;
  logic [31:0] perf_drop;

  fetch_stage #(.RESET_VEC(RV), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .valid_d(valid_d), .instr_d(instr_d), .imm_d(imm_d),
    .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .perf_fetch(perf_fetch), .perf_drop(perf_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // memory model state
  typedef struct {
    logic [31:0] addr;
    int          rdy;
    bit          stale;
  } pend_t;
  pend_t pq[$];
  int gnt_mode = 0;
  int lat_min = 1;
  int lat_max = 1;
  int exp_drop = 0;
  int n_deliv = 0;
  logic [31:0] exp_pc = RV;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_0013;
  endfunction

  // Instruction memory: in-order responses, latency lat_min..lat_max.
  // Entries outstanding at a redirect are marked stale and counted
  // as dropped when they return.
  initial begin
    int cyc;
    int last_rdy;
    int rdy;
    bit g_cap;
    bit rv_cap;
    logic [31:0] a_cap;
    cyc = 0;
    last_rdy = 0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      g_cap  = rst_n && imem_req && imem_gnt;
      a_cap  = imem_addr;
      rv_cap = imem_rvalid;
      if (rst_n && pc_src_e)
        foreach (pq[i]) pq[i].stale = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      case (gnt_mode)
        0:       imem_gnt = 1'b1;
        1:       imem_gnt = ($urandom_range(3, 0) != 0);
        default: imem_gnt = 1'b0;
      endcase
      if (!rst_n) begin
        pq.delete();
        last_rdy = 0;
        exp_drop = 0;
        imem_rvalid = 1'b0;
      end else begin
        if (rv_cap && pq.size() != 0) begin
          if (pq[0].stale) exp_drop++;
          void'(pq.pop_front());
        end
        if (g_cap) begin
          rdy = cyc - 1 + $urandom_range(lat_max, lat_min);
          if (rdy < last_rdy) rdy = last_rdy;
          last_rdy = rdy;
          pq.push_back('{addr: a_cap, rdy: rdy, stale: 1'b0});
        end
        if (pq.size() != 0 && pq[0].rdy <= cyc) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memf(pq[0].addr);
        end else begin
          imem_rvalid = 1'b0;
          imem_rdata  = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // Scoreboard: every real delivery must be the next program-order PC.
  initial begin
    bit p_rst;
    bit p_stall;
    bit p_flush;
    p_rst = 0;
    p_stall = 0;
    p_flush = 0;
    forever begin
      @(negedge clk);
      if (rst_n && p_rst) begin
        if (p_flush) begin
          checks++;
          if (valid_d !== 1'b0 || instr_d !== NOP) begin
            errors++;
            $display("FAIL flush_bubble: valid=%b instr=%h want 0/%h",
                     valid_d, instr_d, NOP);
          end
        end else if (!p_stall && valid_d === 1'b1) begin
          checks++;
          if (pc_d !== exp_pc || instr_d !== memf(exp_pc) ||
              imm_d !== instr_d[31:7] ||
              pc_plus4_d !== exp_pc + 32'd4) begin
            errors++;
            $display("FAIL deliver: pc=%h instr=%h pc4=%h want %h %h %h",
                     pc_d, instr_d, pc_plus4_d, exp_pc,
                     memf(exp_pc), exp_pc + 32'd4);
          end
          exp_pc = exp_pc + 32'd4;
          n_deliv++;
        end else if (!p_stall && valid_d === 1'b0) begin
          checks++;
          if (instr_d !== NOP) begin
            errors++;
            $display("FAIL bubble_nop: instr=%h want %h", instr_d, NOP);
          end
        end
      end
      if (!rst_n) begin
        exp_pc = RV;
        n_deliv = 0;
      end
      p_rst   = rst_n;
      p_stall = stall_d;
      p_flush = flush_d;
      if (rst_n && pc_src_e) exp_pc = {pc_target_e[31:2], 2'b00};
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    pc_src_e = 1'b0;
    pc_target_e = 32'h0;
    gnt_mode = 0;
    lat_min = 1;
    lat_max = 1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string nm, output bit ok);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (valid_d === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: valid_d never rose", nm);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (valid_d !== 1'b0 || instr_d !== NOP || pc_d !== 32'd0 ||
        pc_plus4_d !== 32'd4 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: v=%b i=%h pc=%h p4=%h req=%b",
               valid_d, instr_d, pc_d, pc_plus4_d, imem_req);
    end
    checks++;
    if (perf_fetch !== 32'd0 || perf_drop !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf: got %h %h want 0 0",
               perf_fetch, perf_drop);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RV) begin
      errors++;
      $display("FAIL reset_first_fetch: req=%b addr=%h want 1 %h",
               imem_req, imem_addr, RV);
    end
  endtask

  task automatic test_stream();
    int vcnt;
    do_reset();
    step();
    step();
    step();
    checks++;
    if (valid_d !== 1'b1) begin
      errors++;
      $display("FAIL stream_edge3: valid=%b want 1", valid_d);
    end
    vcnt = 0;
    repeat (10) begin
      step();
      if (valid_d === 1'b1) vcnt++;
    end
    checks++;
    if (vcnt != 10) begin
      errors++;
      $display("FAIL stream_rate: got %0d valid of 10 want 10", vcnt);
    end
  endtask

  task automatic test_stall();
    bit ok;
    do_reset();
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (valid_d === 1'b1 && pc_d === 32'h8) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_reach8: pc=%h never reached 8", pc_d);
    end
    stall_d = 1'b1;
    repeat (4) begin
      step();
      checks++;
      if (valid_d !== 1'b1 || pc_d !== 32'h8 ||
          instr_d !== memf(32'h8)) begin
        errors++;
        $display("FAIL stall_hold: v=%b pc=%h i=%h want 1 8 %h",
                 valid_d, pc_d, instr_d, memf(32'h8));
      end
    end
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_req_off: req=%b want 0", imem_req);
    end
    stall_d = 1'b0;
    step();
    checks++;
    if (valid_d !== 1'b1 || pc_d !== 32'hC) begin
      errors++;
      $display("FAIL stall_rel1: v=%b pc=%h want 1 c", valid_d, pc_d);
    end
    step();
    checks++;
    if (valid_d !== 1'b1 || pc_d !== 32'h10) begin
      errors++;
      $display("FAIL stall_rel2: v=%b pc=%h want 1 10", valid_d, pc_d);
    end
  endtask

  task automatic test_redirect();
    bit ok;
    int base_drop;
    do_reset();
    lat_min = 3;
    lat_max = 3;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pq.size() == 2) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL redir_inflight: got %0d want 2", pq.size());
    end
    base_drop = exp_drop;
    pc_src_e = 1'b1;
    flush_d = 1'b1;
    pc_target_e = 32'h0000_0103;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL redir_no_req: req=%b want 0", imem_req);
    end
    step();
    pc_src_e = 1'b0;
    flush_d = 1'b0;
    wait_valid("redir", ok);
    checks++;
    if (pc_d !== 32'h100) begin
      errors++;
      $display("FAIL redir_target: pc=%h want 100", pc_d);
    end
    checks++;
    if (exp_drop - base_drop != 2) begin
      errors++;
      $display("FAIL redir_drop_model: got %0d want 2",
               exp_drop - base_drop);
    end
    checks++;
`ifdef FETCH_PERF_EN
    if (perf_drop !== 32'(exp_drop)) begin
      errors++;
      $display("FAIL redir_perf_drop: got %0d want %0d",
               perf_drop, exp_drop);
    end
`else
    if (perf_drop !== 32'd0) begin
      errors++;
      $display("FAIL redir_perf_off: got %0d want 0", perf_drop);
    end
`endif
  endtask

  task automatic test_flush_stall();
    bit ok;
    do_reset();
    wait_valid("flush", ok);
    step();
    stall_d = 1'b1;
    flush_d = 1'b1;
    step();
    checks++;
    if (valid_d !== 1'b0 || instr_d !== NOP) begin
      errors++;
      $display("FAIL flush_stall: v=%b i=%h want 0 %h",
               valid_d, instr_d, NOP);
    end
    stall_d = 1'b0;
    flush_d = 1'b0;
    wait_valid("flush_resume", ok);
  endtask

  task automatic test_gnt_low();
    bit ok;
    logic [31:0] held;
    do_reset();
    wait_valid("gnt", ok);
    gnt_mode = 2;
    step();
    held = imem_addr;
    repeat (5) begin
      step();
      checks++;
      if (imem_addr !== held || imem_req !== 1'b1) begin
        errors++;
        $display("FAIL gnt_low_hold: addr=%h req=%b want %h 1",
                 imem_addr, imem_req, held);
      end
    end
    checks++;
    if (valid_d !== 1'b0) begin
      errors++;
      $display("FAIL gnt_low_bubble: valid=%b want 0", valid_d);
    end
    gnt_mode = 0;
    wait_valid("gnt_resume", ok);
    checks++;
    if (pc_d !== held) begin
      errors++;
      $display("FAIL gnt_resume_pc: pc=%h want %h", pc_d, held);
    end
  endtask

  task automatic test_wrap();
    bit seen;
    do_reset();
    step();
    pc_src_e = 1'b1;
    flush_d = 1'b1;
    pc_target_e = 32'hFFFF_FFF6;
    step();
    pc_src_e = 1'b0;
    flush_d = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (valid_d === 1'b1 && pc_d === 32'h0) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wrap_zero: pc=%h never wrapped to 0", pc_d);
    end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    do_reset();
    lat_min = 4;
    lat_max = 4;
    step();
    step();
    stall_d = 1'b1;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (imem_req === 1'b0) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rstmid_fill: req=%b never dropped", imem_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_d !== 1'b0 || instr_d !== NOP || pc_d !== 32'd0 ||
        pc_plus4_d !== 32'd4 || imem_req !== 1'b0 ||
        perf_fetch !== 32'd0 || perf_drop !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_async: v=%b i=%h pc=%h p4=%h req=%b pf=%h",
               valid_d, instr_d, pc_d, pc_plus4_d, imem_req, perf_fetch);
    end
    stall_d = 1'b0;
    lat_min = 1;
    lat_max = 1;
    step();
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_addr !== RV || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_refetch: addr=%h req=%b want %h 1",
               imem_addr, imem_req, RV);
    end
    wait_valid("rstmid", ok);
    checks++;
    if (pc_d !== RV) begin
      errors++;
      $display("FAIL rstmid_first: pc=%h want %h", pc_d, RV);
    end
  endtask

  task automatic test_random();
    int d0;
    do_reset();
    gnt_mode = 1;
    lat_min = 1;
    lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      step();
      stall_d = ($urandom_range(4, 0) == 0);
      if ($urandom_range(24, 0) == 0) begin
        pc_src_e = 1'b1;
        flush_d = 1'b1;
        pc_target_e = $urandom & 32'h0000_FFFF;
      end else begin
        pc_src_e = 1'b0;
        flush_d = ($urandom_range(29, 0) == 0);
      end
    end
    step();
    pc_src_e = 1'b0;
    flush_d = 1'b0;
    stall_d = 1'b1;
    repeat (10) step();
    d0 = n_deliv;
    checks++;
    if (d0 < 50) begin
      errors++;
      $display("FAIL rand_progress: got %0d deliveries want >=50", d0);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_fetch !== 32'(n_deliv)) begin
      errors++;
      $display("FAIL rand_perf_fetch: got %0d want %0d",
               perf_fetch, n_deliv);
    end
    checks++;
    if (perf_drop !== 32'(exp_drop)) begin
      errors++;
      $display("FAIL rand_perf_drop: got %0d want %0d",
               perf_drop, exp_drop);
    end
`else
    checks++;
    if (perf_fetch !== 32'd0 || perf_drop !== 32'd0) begin
      errors++;
      $display("FAIL rand_perf_off: got %0d %0d want 0 0",
               perf_fetch, perf_drop);
    end
`endif
    stall_d = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    pc_src_e = 1'b0;
    pc_target_e = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_flush_stall();
    test_gnt_low();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
